// File: rtl/piece_move_animator.sv
// piece_move_animator: slides one chess sprite from a source square to a
// destination square, one step per video frame (vs falling edge). Reports
// landing with a done pulse and, for captures, the captured square.
module piece_move_animator #(
  parameter int STEP_PX   = 4,
  parameter int SQ_PX     = 60,
  parameter int BOARD_MAX = 420
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       vs,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_src,
  input  logic [5:0] req_dst,
  input  logic       req_dst_occupied,
  output logic       anim_active,
  output logic [9:0] anim_offsetX,
  output logic [9:0] anim_offsetY,
  output logic [5:0] hide_sq,
  output logic       done,
  output logic       cap_valid,
  output logic [5:0] cap_sq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_LAND = 2'd2
  } state_e;

  localparam logic signed [10:0] STEP_S = 11'(STEP_PX);
  localparam logic [9:0]         STEP_U = 10'(STEP_PX);

  // Board-relative pixel position of a rank/file index, kept inside the board.
  function automatic logic [9:0] sq_to_px(input logic [2:0] idx);
    logic [15:0] px;
    px = 16'(idx) * 16'(SQ_PX);
    if (px > 16'(BOARD_MAX)) begin
      sq_to_px = 10'(BOARD_MAX);
    end else begin
      sq_to_px = px[9:0];
    end
  endfunction

  // One frame of motion on a single axis: full step, or snap when within reach.
  function automatic logic [9:0] step_axis(input logic [9:0] cur, input logic [9:0] tgt);
    logic signed [10:0] diff;
    logic [9:0]         nxt;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_S) begin
      nxt = cur + STEP_U;
    end else if (diff < -STEP_S) begin
      nxt = cur - STEP_U;
    end else begin
      nxt = tgt;
    end
    return nxt;
  endfunction

  state_e     state_q, state_d;
  logic       vs_q;
  logic       req_ready_q, req_ready_d;
  logic       anim_active_q, anim_active_d;
  logic [9:0] off_x_q, off_x_d;
  logic [9:0] off_y_q, off_y_d;
  logic [5:0] hide_sq_q, hide_sq_d;
  logic       done_q, done_d;
  logic       cap_valid_q, cap_valid_d;
  logic [5:0] cap_sq_q, cap_sq_d;
  logic [5:0] dst_q, dst_d;
  logic       occ_q, occ_d;
  logic       tick_s;
  logic [9:0] tgt_x_s;
  logic [9:0] tgt_y_s;

  assign tick_s  = vs_q & ~vs;
  assign tgt_x_s = sq_to_px(dst_q[2:0]);
  assign tgt_y_s = sq_to_px(dst_q[5:3]);

  // Next-state and next-output computation for the move sequencer.
  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    anim_active_d = anim_active_q;
    off_x_d       = off_x_q;
    off_y_d       = off_y_q;
    hide_sq_d     = hide_sq_q;
    done_d        = 1'b0;
    cap_valid_d   = 1'b0;
    cap_sq_d      = cap_sq_q;
    dst_d         = dst_q;
    occ_d         = occ_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          dst_d         = req_dst;
          occ_d         = req_dst_occupied;
          off_x_d       = sq_to_px(req_src[2:0]);
          off_y_d       = sq_to_px(req_src[5:3]);
          hide_sq_d     = req_src;
          req_ready_d   = 1'b0;
          anim_active_d = 1'b1;
          state_d       = ST_MOVE;
        end else begin
          req_ready_d   = 1'b1;
          anim_active_d = 1'b0;
        end
      end
      ST_MOVE: begin
        if (tick_s) begin
          if ((off_x_q == tgt_x_s) && (off_y_q == tgt_y_s)) begin
            state_d     = ST_LAND;
            done_d      = 1'b1;
            cap_valid_d = occ_q;
            cap_sq_d    = dst_q;
          end else begin
            off_x_d = step_axis(off_x_q, tgt_x_s);
            off_y_d = step_axis(off_y_q, tgt_y_s);
          end
        end else begin
          state_d = ST_MOVE;
        end
      end
      ST_LAND: begin
        state_d       = ST_IDLE;
        req_ready_d   = 1'b1;
        anim_active_d = 1'b0;
      end
      default: begin
        state_d       = ST_IDLE;
        req_ready_d   = 1'b1;
        anim_active_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any move in flight.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      vs_q          <= 1'b1;
      req_ready_q   <= 1'b1;
      anim_active_q <= 1'b0;
      off_x_q       <= 10'd0;
      off_y_q       <= 10'd0;
      hide_sq_q     <= 6'd0;
      done_q        <= 1'b0;
      cap_valid_q   <= 1'b0;
      cap_sq_q      <= 6'd0;
      dst_q         <= 6'd0;
      occ_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs;
      req_ready_q   <= req_ready_d;
      anim_active_q <= anim_active_d;
      off_x_q       <= off_x_d;
      off_y_q       <= off_y_d;
      hide_sq_q     <= hide_sq_d;
      done_q        <= done_d;
      cap_valid_q   <= cap_valid_d;
      cap_sq_q      <= cap_sq_d;
      dst_q         <= dst_d;
      occ_q         <= occ_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign anim_active  = anim_active_q;
  assign anim_offsetX = off_x_q;
  assign anim_offsetY = off_y_q;
  assign hide_sq      = hide_sq_q;
  assign done         = done_q;
  assign cap_valid    = cap_valid_q;
  assign cap_sq       = cap_sq_q;

endmodule
